// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, stall, flush
// and an optional one-entry skid buffer that registers the backward ready path.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 64,
  parameter int unsigned        CTRL_W      = 16,
  parameter int unsigned        SKID        = 1,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  localparam int unsigned OCC_W = 2;

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [OCC_W-1:0]  occ_q,        occ_d;

  logic in_xfer;
  logic out_xfer;

  // Stall masks only the downstream acceptance.
  assign out_xfer = main_valid_q & out_ready & ~stall;

  // Ready is a pure register output with a skid entry, combinational without.
  generate
    if (SKID != 0) begin : g_ready_reg
      assign in_ready = ~skid_valid_q;
    end else begin : g_ready_comb
      assign in_ready = ~main_valid_q | out_xfer;
    end
  endgenerate

  assign in_xfer = in_valid & in_ready;

  // Next-state: flush clears, otherwise refill main from skid or input, park in skid when main is held.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = BUBBLE_CTRL;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_xfer) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = in_xfer;
        if (in_xfer) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = BUBBLE_CTRL;
      end
    end else if (in_xfer && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
    occ_d = OCC_W'(main_valid_d) + OCC_W'(skid_valid_d);
  end

  // State register; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= BUBBLE_CTRL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= BUBBLE_CTRL;
      occ_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      occ_q        <= occ_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage from shared stimulus and checks both
// against a queue-based reference model every cycle.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 16;
  localparam logic [CW-1:0] BUB = 16'hB0B0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } bundle_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic          stall;
  logic          flush;

  logic          in_ready_w  [2];
  logic          out_valid_w [2];
  logic [DW-1:0] out_data_w  [2];
  logic [CW-1:0] out_ctrl_w  [2];
  logic [1:0]    occ_w       [2];

  // Reference state: index 0 = SKID=0 instance, index 1 = SKID=1 instance.
  bundle_t       q    [2][$];
  logic [DW-1:0] last [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .BUBBLE_CTRL(BUB)) u_skid0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_data(out_data_w[0]), .out_ctrl(out_ctrl_w[0]),
    .stall(stall), .flush(flush), .occupancy(occ_w[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .BUBBLE_CTRL(BUB)) u_skid1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_data(out_data_w[1]), .out_ctrl(out_ctrl_w[1]),
    .stall(stall), .flush(flush), .occupancy(occ_w[1])
  );

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model for the coming posedge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy,
                     input logic stl, input logic fl, input logic r);
    int      sz;
    logic    exp_rdy, ox, ix;
    bundle_t b;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = CW'($urandom);
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    rst       = r;
    #1;
    for (int i = 0; i < 2; i++) begin
      sz = q[i].size();
      if (sz > 0) last[i] = q[i][0].d;
      exp_rdy = (i == 1) ? (sz < 2) : ((sz == 0) || (ordy && !stl));
      check($sformatf("s%0d_in_ready", i),  64'(in_ready_w[i]),  64'(exp_rdy));
      check($sformatf("s%0d_out_valid", i), 64'(out_valid_w[i]), 64'(sz > 0));
      check($sformatf("s%0d_out_data", i),  out_data_w[i],       last[i]);
      check($sformatf("s%0d_out_ctrl", i),  64'(out_ctrl_w[i]),  64'((sz > 0) ? q[i][0].c : BUB));
      check($sformatf("s%0d_occupancy", i), 64'(occ_w[i]),       64'(sz));
      if (r) begin
        q[i].delete();
        last[i] = '0;
      end else if (fl) begin
        q[i].delete();
      end else begin
        ox = (sz > 0) && ordy && !stl;
        ix = v && exp_rdy;
        if (ox) void'(q[i].pop_front());
        if (ix) begin
          b.d = d;
          b.c = in_ctrl;
          q[i].push_back(b);
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    last[0] = '0; last[1] = '0;
    repeat (2) @(posedge clk);

    // Streaming at full rate.
    for (int k = 1; k <= 8; k++) cyc(1'b1, DW'(k), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Backpressure: A, B, C offered with downstream blocked, then released.
    cyc(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Stall holds a valid bundle despite out_ready.
    cyc(1'b1, 64'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Stall rising with new input offered.
    cyc(1'b1, 64'h61, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h62, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 64'h63, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Flush with two held bundles and a same-cycle input.
    cyc(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset with two held bundles.
    cyc(1'b1, 64'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          {32'($urandom), 32'($urandom)},
          1'($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 9) < 2),
          1'($urandom_range(0, 49) == 0),
          1'($urandom_range(0, 149) == 0));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
